// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the data-memory access sequencer: access size codes,
// sequencer states and the alignment/legality check.
package mem_access_unit_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_BAD  = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RD   = 2'b01,
        ST_WR   = 2'b10,
        ST_RESP = 2'b11
    } state_e;

    // Illegal size code or an address not naturally aligned to the access size.
    function automatic logic access_err(input logic [1:0] size, input logic [1:0] lo);
        logic err;
        case (size)
            SZ_BYTE: err = 1'b0;
            SZ_HALF: err = lo[0];
            SZ_WORD: err = (lo != 2'b00);
            default: err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/mem_access_unit_load_ext.sv
// Load lane extraction: picks the byte/half lane of a little-endian word and
// zero- or sign-extends it to 32 bits.
module mem_access_unit_load_ext
    import mem_access_unit_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        sign,
    output logic [31:0] result
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane select followed by extension according to the access size.
    always_comb begin
        byte_s = word[{offset, 3'b000} +: 8];
        half_s = word[{offset[1], 4'b0000} +: 16];
        case (size)
            SZ_BYTE: result = {{24{sign & byte_s[7]}}, byte_s};
            SZ_HALF: result = {{16{sign & half_s[15]}}, half_s};
            SZ_WORD: result = word;
            default: result = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Data-memory access sequencer for the multicycle MIPS datapath: byte/half/word
// loads and stores over a handshaked word-addressed memory, sub-word stores by RMW.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_sign,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack
);

    state_e            state_r;
    state_e            state_s;
    logic              req_ready_r;
    logic              resp_valid_r;
    logic [31:0]       resp_rdata_r;
    logic              resp_err_r;
    logic              mem_req_r;
    logic              mem_we_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [31:0]       mem_wdata_r;

    logic              we_r;
    logic [1:0]        size_r;
    logic              sign_r;
    logic [1:0]        lo_r;
    logic [15:0]       wdata_r;

    logic              accept_s;
    logic [31:0]       resp_rdata_s;
    logic              resp_err_s;
    logic [ADDR_W-1:0] mem_addr_s;
    logic [31:0]       mem_wdata_s;
    logic [31:0]       ext_s;
    logic [31:0]       merge_s;

    mem_access_unit_load_ext u_load_ext (
        .word   (mem_rdata),
        .offset (lo_r),
        .size   (size_r),
        .sign   (sign_r),
        .result (ext_s)
    );

    // Read-modify-write merge: only the addressed lane takes the new store data.
    always_comb begin
        merge_s = mem_rdata;
        case (size_r)
            SZ_BYTE: merge_s[{lo_r, 3'b000} +: 8]   = wdata_r[7:0];
            SZ_HALF: merge_s[{lo_r[1], 4'b0000} +: 16] = wdata_r;
            default: merge_s = mem_rdata;
        endcase
    end

    // Next-state logic plus the values loaded into the registered outputs.
    always_comb begin
        state_s      = state_r;
        accept_s     = 1'b0;
        resp_rdata_s = 32'h0000_0000;
        resp_err_s   = 1'b0;
        mem_addr_s   = mem_addr_r;
        mem_wdata_s  = mem_wdata_r;
        case (state_r)
            ST_IDLE: begin
                if (req_valid && req_ready_r) begin
                    accept_s = 1'b1;
                    if (access_err(req_size, req_addr[1:0])) begin
                        state_s    = ST_RESP;
                        resp_err_s = 1'b1;
                    end else if (req_we && (req_size == SZ_WORD)) begin
                        state_s     = ST_WR;
                        mem_addr_s  = {req_addr[ADDR_W-1:2], 2'b00};
                        mem_wdata_s = req_wdata;
                    end else begin
                        state_s    = ST_RD;
                        mem_addr_s = {req_addr[ADDR_W-1:2], 2'b00};
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RD: begin
                if (mem_req_r && mem_ack) begin
                    if (we_r) begin
                        state_s     = ST_WR;
                        mem_wdata_s = merge_s;
                    end else begin
                        state_s      = ST_RESP;
                        resp_rdata_s = ext_s;
                    end
                end else begin
                    state_s = ST_RD;
                end
            end
            ST_WR: begin
                if (mem_req_r && mem_ack) begin
                    state_s = ST_RESP;
                end else begin
                    state_s = ST_WR;
                end
            end
            ST_RESP: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // State, registered outputs and captured request fields.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            req_ready_r  <= 1'b0;
            resp_valid_r <= 1'b0;
            resp_rdata_r <= 32'h0000_0000;
            resp_err_r   <= 1'b0;
            mem_req_r    <= 1'b0;
            mem_we_r     <= 1'b0;
            mem_addr_r   <= {ADDR_W{1'b0}};
            mem_wdata_r  <= 32'h0000_0000;
            we_r         <= 1'b0;
            size_r       <= 2'b00;
            sign_r       <= 1'b0;
            lo_r         <= 2'b00;
            wdata_r      <= 16'h0000;
        end else begin
            state_r      <= state_s;
            req_ready_r  <= (state_s == ST_IDLE);
            resp_valid_r <= (state_s == ST_RESP);
            resp_rdata_r <= resp_rdata_s;
            resp_err_r   <= resp_err_s;
            mem_req_r    <= (state_s == ST_RD) || (state_s == ST_WR);
            mem_we_r     <= (state_s == ST_WR);
            mem_addr_r   <= mem_addr_s;
            mem_wdata_r  <= mem_wdata_s;
            if (accept_s) begin
                we_r    <= req_we;
                size_r  <= req_size;
                sign_r  <= req_sign;
                lo_r    <= req_addr[1:0];
                wdata_r <= req_wdata[15:0];
            end
        end
    end

    assign req_ready  = req_ready_r;
    assign resp_valid = resp_valid_r;
    assign resp_rdata = resp_rdata_r;
    assign resp_err   = resp_err_r;
    assign mem_req    = mem_req_r;
    assign mem_we     = mem_we_r;
    assign mem_addr   = mem_addr_r;
    assign mem_wdata  = mem_wdata_r;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed vector table, hand-written
// wait-state/reset/spurious-ack sequences and random traffic against a lane model.
module tb_mem_access_unit;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_sign;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    int errors = 0;
    int checks = 0;

    logic [31:0] phys_mem [0:1023];
    logic [31:0] ref_mem  [0:1023];
    int          wait_rd = 0;
    int          wait_wr = 0;
    logic        force_ack = 1'b0;
    int          wr_count = 0;
    int          rd_count = 0;
    logic [31:0] last_wr_addr = 32'h0;
    logic [31:0] last_wr_data = 32'h0;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sign;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        pre_en;
        logic [31:0] pre_val;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    mem_access_unit #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_sign(req_sign), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] size);
        return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic ref_err(input logic [1:0] size, input logic [31:0] addr);
        return (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) || (size == 2'd2 && addr % 4 != 0);
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] off,
                                             input logic [1:0] size, input logic sign);
        int nb;
        logic [63:0] m;
        logic [63:0] v;
        nb = nbytes(size);
        m  = (64'd1 << (8 * nb)) - 64'd1;
        v  = ({32'h0, w} >> (8 * off)) & m;
        if (sign && nb < 4 && v[8 * nb - 1]) v = v | ~m;
        return v[31:0];
    endfunction

    function automatic logic [31:0] ref_store(input logic [31:0] w, input logic [1:0] off,
                                              input logic [1:0] size, input logic [31:0] d);
        logic [63:0] m;
        m = ((64'd1 << (8 * nbytes(size))) - 64'd1) << (8 * off);
        return (w & ~m[31:0]) | ((d << (8 * off)) & m[31:0]);
    endfunction

    function automatic int ref_lat(input logic we, input logic [1:0] size, input logic err);
        int l;
        if (err) return 1;
        l = 1;
        if (!(we && size == 2'd2)) l += wait_rd + 1;
        if (we) l += wait_wr + 1;
        return l;
    endfunction

    function automatic vec_t mk(input logic we, input logic [1:0] size, input logic sign,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic pre_en, input logic [31:0] pre_val,
                                input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
        vec_t v;
        v = '{we, size, sign, addr, wdata, pre_en, pre_val, exp_rdata, exp_err, exp_lat};
        return v;
    endfunction

    // Memory responder: configurable wait states, checks request stability while held.
    initial begin
        int          cnt;
        int          cur_wait;
        logic        hold;
        logic [31:0] h_addr;
        logic [31:0] h_wdata;
        logic        h_we;
        cnt = 0; hold = 1'b0; h_addr = 32'h0; h_wdata = 32'h0; h_we = 1'b0;
        mem_ack = 1'b0; mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (hold && mem_req) begin
                check("stable_addr", mem_addr, h_addr);
                check("stable_we", 32'(mem_we), 32'(h_we));
                if (h_we) check("stable_wdata", mem_wdata, h_wdata);
            end
            if (mem_req) begin
                cur_wait = mem_we ? wait_wr : wait_rd;
                if (cnt >= cur_wait) begin
                    mem_ack = 1'b1;
                    if (mem_we) begin
                        phys_mem[mem_addr[11:2]] = mem_wdata;
                        wr_count++;
                        last_wr_addr = mem_addr;
                        last_wr_data = mem_wdata;
                        mem_rdata = $urandom;
                    end else begin
                        mem_rdata = phys_mem[mem_addr[11:2]];
                        rd_count++;
                    end
                    cnt = 0; hold = 1'b0;
                end else begin
                    mem_ack = 1'b0; mem_rdata = $urandom; cnt++;
                    hold = 1'b1; h_addr = mem_addr; h_we = mem_we; h_wdata = mem_wdata;
                end
            end else begin
                mem_ack = force_ack; mem_rdata = $urandom; cnt = 0; hold = 1'b0;
            end
        end
    end

    task automatic do_req(input logic we, input logic [1:0] size, input logic sign,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_err,
                          input int exp_lat, input string name);
        int          k;
        int          wr0;
        int          rd0;
        int          lat;
        logic        got;
        logic        rdy_bad;
        logic        mreq_seen;
        logic        rd_exp;
        logic        wr_exp;
        logic [31:0] exp_word;
        k = 0;
        while (!req_ready && k < 50) begin @(negedge clk); k++; end
        if (!req_ready) begin
            check({name, "_ready_timeout"}, 32'h0, 32'h1);
            return;
        end
        wr0 = wr_count; rd0 = rd_count;
        req_valid = 1'b1; req_we = we; req_size = size; req_sign = sign;
        req_addr = addr; req_wdata = wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
        got = 1'b0; rdy_bad = 1'b0; mreq_seen = 1'b0; lat = 0;
        for (int c = 1; c <= 60 && !got; c++) begin
            @(negedge clk);
            if (mem_req) mreq_seen = 1'b1;
            if (resp_valid) begin
                got = 1'b1; lat = c;
            end else if (req_ready) begin
                rdy_bad = 1'b1;
            end
        end
        if (!got) begin
            check({name, "_resp_timeout"}, 32'h0, 32'h1);
            return;
        end
        rd_exp = !exp_err && !(we && size == 2'd2);
        wr_exp = !exp_err && we;
        check({name, "_rdata"}, resp_rdata, exp_rdata);
        check({name, "_err"}, 32'(resp_err), 32'(exp_err));
        check({name, "_lat"}, 32'(lat), 32'(exp_lat));
        check({name, "_busy_ready"}, 32'(rdy_bad), 32'h0);
        check({name, "_memreq_seen"}, 32'(mreq_seen), 32'(!exp_err));
        check({name, "_memreq_drop"}, 32'(mem_req), 32'h0);
        check({name, "_reads"}, 32'(rd_count - rd0), 32'(rd_exp));
        check({name, "_writes"}, 32'(wr_count - wr0), 32'(wr_exp));
        if (wr_exp) begin
            exp_word = ref_store(ref_mem[addr[11:2]], addr[1:0], size, wdata);
            ref_mem[addr[11:2]] = exp_word;
            check({name, "_wr_addr"}, last_wr_addr, {addr[31:2], 2'b00});
            check({name, "_wr_data"}, last_wr_data, exp_word);
        end
        @(negedge clk);
        check({name, "_pulse"}, 32'(resp_valid), 32'h0);
        check({name, "_ready_back"}, 32'(req_ready), 32'h1);
    endtask

    // Global watchdog.
    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t        vecs [0:16];
        logic        r_we;
        logic [1:0]  r_size;
        logic        r_sign;
        logic        r_err;
        logic [31:0] r_addr;
        logic [31:0] r_wdata;
        logic [31:0] r_exp;
        int          wc0;
        int          sz_pick;
        logic        bad;

        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_sign = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0;
        for (int i = 0; i < 1024; i++) begin
            phys_mem[i] = $urandom;
            ref_mem[i]  = phys_mem[i];
        end

        vecs[0]  = mk(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 1'b1, 32'h80FF1234, 32'hFFFFFF80, 1'b0, 2);
        vecs[1]  = mk(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 1'b0, 32'h0, 32'h00000080, 1'b0, 2);
        vecs[2]  = mk(1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 1'b0, 32'h0, 32'h000080FF, 1'b0, 2);
        vecs[3]  = mk(1'b0, 2'b01, 1'b1, 32'h102, 32'h0, 1'b0, 32'h0, 32'hFFFF80FF, 1'b0, 2);
        vecs[4]  = mk(1'b0, 2'b10, 1'b1, 32'h100, 32'h0, 1'b0, 32'h0, 32'h80FF1234, 1'b0, 2);
        vecs[5]  = mk(1'b0, 2'b00, 1'b1, 32'h101, 32'h0, 1'b0, 32'h0, 32'h00000012, 1'b0, 2);
        vecs[6]  = mk(1'b1, 2'b01, 1'b0, 32'h202, 32'h0000BEEF, 1'b1, 32'h11223344, 32'h0, 1'b0, 3);
        vecs[7]  = mk(1'b0, 2'b10, 1'b0, 32'h200, 32'h0, 1'b0, 32'h0, 32'hBEEF3344, 1'b0, 2);
        vecs[8]  = mk(1'b0, 2'b10, 1'b0, 32'h201, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 1);
        vecs[9]  = mk(1'b0, 2'b11, 1'b0, 32'h200, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 1);
        vecs[10] = mk(1'b0, 2'b01, 1'b1, 32'h101, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 1);
        vecs[11] = mk(1'b1, 2'b01, 1'b0, 32'h203, 32'h1234, 1'b0, 32'h0, 32'h0, 1'b1, 1);
        vecs[12] = mk(1'b1, 2'b10, 1'b0, 32'h400, 32'hCAFEF00D, 1'b0, 32'h0, 32'h0, 1'b0, 2);
        vecs[13] = mk(1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 1'b0, 32'h0, 32'hCAFEF00D, 1'b0, 2);
        vecs[14] = mk(1'b1, 2'b00, 1'b0, 32'h301, 32'h000000AA, 1'b1, 32'h01020304, 32'h0, 1'b0, 3);
        vecs[15] = mk(1'b0, 2'b00, 1'b0, 32'h301, 32'h0, 1'b0, 32'h0, 32'h000000AA, 1'b0, 2);
        vecs[16] = mk(1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 1'b0, 32'h0, 32'h0102AA04, 1'b0, 2);

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'h0);
        check("rst_resp_valid", 32'(resp_valid), 32'h0);
        check("rst_resp_err", 32'(resp_err), 32'h0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_mem_req", 32'(mem_req), 32'h0);
        check("rst_mem_we", 32'(mem_we), 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 32'(req_ready), 32'h1);

        // Directed table, zero-wait memory, issued back to back
        wait_rd = 0; wait_wr = 0;
        for (int i = 0; i <= 16; i++) begin
            if (vecs[i].pre_en) begin
                phys_mem[vecs[i].addr[11:2]] = vecs[i].pre_val;
                ref_mem[vecs[i].addr[11:2]]  = vecs[i].pre_val;
            end
            do_req(vecs[i].we, vecs[i].size, vecs[i].sign, vecs[i].addr, vecs[i].wdata,
                   vecs[i].exp_rdata, vecs[i].exp_err, vecs[i].exp_lat, $sformatf("vec%0d", i));
        end

        // SB with three wait cycles on both the read and the write
        phys_mem[32'h300 >> 2] = 32'h11223344;
        ref_mem[32'h300 >> 2]  = 32'h11223344;
        wait_rd = 3; wait_wr = 3;
        do_req(1'b1, 2'b00, 1'b0, 32'h301, 32'h000000AA, 32'h0, 1'b0, 9, "sb_wait");
        check("sb_wait_word", last_wr_data, 32'h1122AA44);

        // Reset in the middle of a write: aborted, no response, no write
        wait_rd = 0; wait_wr = 6; wc0 = wr_count;
        for (int k = 0; k < 50 && !req_ready; k++) @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_sign = 1'b0;
        req_addr = 32'h500; req_wdata = 32'h12345678;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("abort_in_wr", {30'h0, mem_req, mem_we}, 32'h3);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_mem_req", 32'(mem_req), 32'h0);
        check("abort_no_resp", 32'(resp_valid), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("abort_ready", 32'(req_ready), 32'h1);
        bad = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (resp_valid || mem_req) bad = 1'b1;
        end
        check("abort_quiet", 32'(bad), 32'h0);
        check("abort_no_write", 32'(wr_count - wc0), 32'h0);

        // Ack while no request is outstanding is ignored
        wait_wr = 0;
        force_ack = 1'b1;
        bad = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (resp_valid || mem_req || !req_ready) bad = 1'b1;
        end
        force_ack = 1'b0;
        check("spurious_ack", 32'(bad), 32'h0);

        // Random traffic against the lane model
        for (int n = 0; n < 150; n++) begin
            wait_rd = $urandom_range(0, 2);
            wait_wr = $urandom_range(0, 2);
            r_we    = 1'($urandom_range(0, 1));
            sz_pick = $urandom_range(0, 9);
            r_size  = (sz_pick < 3) ? 2'd0 : (sz_pick < 6) ? 2'd1 : (sz_pick < 9) ? 2'd2 : 2'd3;
            r_sign  = 1'($urandom_range(0, 1));
            r_wdata = $urandom;
            r_addr  = 32'($urandom_range(0, 4095));
            if ($urandom_range(0, 3) != 0 && r_size != 2'd3)
                r_addr = r_addr & ~(32'(nbytes(r_size)) - 32'd1);
            r_err = ref_err(r_size, r_addr);
            r_exp = (r_err || r_we) ? 32'h0 : ref_load(ref_mem[r_addr[11:2]], r_addr[1:0], r_size, r_sign);
            do_req(r_we, r_size, r_sign, r_addr, r_wdata, r_exp, r_err,
                   ref_lat(r_we, r_size, r_err), "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
